// File: rtl/anita_buffer_deadtime_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : anita_buffer_deadtime_gen
//  Purpose  : Ring-ordered digitizer buffer tracker producing the 250 MHz dead
//             flag, plus accepted/dropped trigger pulses.
//  Revision : 1.0  initial release
// ============================================================================
module anita_buffer_deadtime_gen #(
    parameter int NBUF    = 4,
    parameter int BUF_W   = 2,
    parameter int HOLDOFF = 32
) (
    input  logic             clk250_i,
    input  logic             rst_n_i,
    input  logic             trig_i,
    input  logic [NBUF-1:0]  clear_i,
    input  logic             disable_i,
    output logic             trig_accept_o,
    output logic [BUF_W-1:0] trig_buf_o,
    output logic             trig_drop_o,
    output logic [NBUF-1:0]  occupancy_o,
    output logic             dead_o,
    output logic             clear_err_o
);

    localparam logic [7:0]      c_HOLDOFF_LOAD = 8'(HOLDOFF - 1);
    localparam logic [NBUF-1:0] c_ONE          = NBUF'(1);

    typedef enum logic [1:0] {
        ST_LIVE    = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_nxt;
    logic [BUF_W-1:0] r_wptr;
    logic [NBUF-1:0]  r_occ;
    logic [NBUF-1:0]  w_occ_nxt;
    logic [NBUF-1:0]  w_alloc;
    logic             w_next_busy;
    logic             w_accept;
    logic             r_accept;
    logic             r_drop;
    logic             r_dead;
    logic             r_err;
    logic [BUF_W-1:0] r_buf;

    // Acceptance and FULL exit both look at pre-edge occupancy, so a clear
    // landing on the same edge never opens the ring early.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_next_busy = r_occ[r_wptr];
        w_accept    = trig_i & (r_state == ST_LIVE) & ~disable_i & ~w_next_busy;
        w_alloc     = w_accept ? (c_ONE << r_wptr) : '0;
        w_occ_nxt   = (r_occ & ~clear_i) | w_alloc;

        case (r_state)
            ST_LIVE: begin
                if (w_accept) begin
                    w_state_nxt = ST_HOLDOFF;
                    w_cnt_nxt   = c_HOLDOFF_LOAD;
                end
            end
            ST_HOLDOFF: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = w_next_busy ? ST_FULL : ST_LIVE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_FULL: begin
                if (!w_next_busy) begin
                    w_state_nxt = ST_LIVE;
                end
            end
            default: begin
                w_state_nxt = ST_LIVE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= ST_LIVE;
            r_cnt    <= 8'd0;
            r_wptr   <= '0;
            r_occ    <= '0;
            r_accept <= 1'b0;
            r_drop   <= 1'b0;
            r_buf    <= '0;
            r_dead   <= 1'b1;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_occ    <= w_occ_nxt;
            r_accept <= w_accept;
            r_drop   <= trig_i & ~w_accept;
            r_dead   <= (w_state_nxt != ST_LIVE) | disable_i;
            // A clear aimed at the buffer being allocated is also caught here,
            // since that bit is free before the edge.
            r_err    <= r_err | (|(clear_i & ~r_occ));
            if (w_accept) begin
                r_buf  <= r_wptr;
                r_wptr <= r_wptr + BUF_W'(1);
            end
        end
    end

    assign trig_accept_o = r_accept;
    assign trig_buf_o    = r_buf;
    assign trig_drop_o   = r_drop;
    assign occupancy_o   = r_occ;
    assign dead_o        = r_dead;
    assign clear_err_o   = r_err;

endmodule
`default_nettype wire
